// File: rtl/axis_xbar_traffic_gen.sv
// AXI-Stream traffic generator: credit-paced packet injection with timestamped
// headers, so a downstream checker can measure router load and latency.
module axis_xbar_traffic_gen #(
    parameter int          DWIDTH    = 64,
    parameter int          NUM_DESTS = 20,
    parameter int          DEST_W    = 5,
    parameter int          MTU_LOG2  = 5,
    parameter logic [7:0]  SRC_ID    = 8'd0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [15:0]         cfg_num_pkts,
    input  logic [MTU_LOG2:0]   cfg_lpp,
    input  logic [6:0]          cfg_inj_rate,
    input  logic [1:0]          cfg_pattern,
    input  logic [DEST_W-1:0]   cfg_fixed_dest,
    output logic [DWIDTH-1:0]   m_axis_tdata,
    output logic [DEST_W-1:0]   m_axis_tdest,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pkts_sent
);
    localparam int                LPP_W     = MTU_LOG2 + 1;
    localparam logic [LPP_W-1:0]  MAX_LPP   = LPP_W'(1 << MTU_LOG2);
    localparam logic [DEST_W:0]   NDEST     = (DEST_W+1)'(NUM_DESTS);
    localparam logic [DEST_W-1:0] LAST_DEST = DEST_W'(NUM_DESTS - 1);
    localparam logic [7:0]        SRC_COMP  = ~SRC_ID;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_FINISH} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         acc_reg, acc_next;
    logic [31:0]        ts_cnt_reg, ts_hold_reg, ts_value;
    logic               ts_held_reg;
    logic [15:0]        lfsr_reg, lfsr_step;
    logic [15:0]        num_pkts_reg, pkts_sent_reg, seq_reg;
    logic [LPP_W-1:0]   lpp_reg, lpp_clamped, beat_reg;
    logic [6:0]         rate_reg, rate_clamped;
    logic [1:0]         pattern_reg, pattern_sel;
    logic [DEST_W-1:0]  fixed_dest_reg, fixed_sel, rr_reg, rr_sel, rr_adv;
    logic [DEST_W-1:0]  dest_reg, dest_new;
    logic               stop_reg;
    logic               active, valid_int, hs, is_last, last_hs, finish_cond;
    logic               start_acc, hdr_entry;
    logic [8:0]         acc_sum;
    logic [63:0]        beat_data;

    // Values at or above NUM_DESTS fold back by a single subtraction.
    function automatic logic [DEST_W-1:0] fold_dest(input logic [DEST_W-1:0] v);
        if ({1'b0, v} >= NDEST) return v - NDEST[DEST_W-1:0];
        return v;
    endfunction

    assign active      = (state_reg == S_HDR) || (state_reg == S_PAYLOAD);
    assign valid_int   = active && (acc_reg >= 8'd100);
    assign hs          = valid_int && m_axis_tready;
    assign is_last     = (state_reg == S_PAYLOAD) && (beat_reg == lpp_reg - LPP_W'(1));
    assign last_hs     = hs && is_last;
    assign finish_cond = (pkts_sent_reg + 16'd1 == num_pkts_reg) || stop_reg || cfg_stop;
    assign start_acc   = (state_reg == S_IDLE) && cfg_start;
    assign hdr_entry   = (state_reg != S_HDR) && (state_next == S_HDR);
    assign ts_value    = ts_held_reg ? ts_hold_reg : ts_cnt_reg;

    assign lpp_clamped  = (cfg_lpp < LPP_W'(2)) ? LPP_W'(2) :
                          (cfg_lpp > MAX_LPP)   ? MAX_LPP : cfg_lpp;
    assign rate_clamped = (cfg_inj_rate == 7'd0)   ? 7'd1   :
                          (cfg_inj_rate > 7'd100)  ? 7'd100 : cfg_inj_rate;

    // The first header of a run is chosen before the config registers load.
    assign pattern_sel = (state_reg == S_IDLE) ? cfg_pattern    : pattern_reg;
    assign fixed_sel   = (state_reg == S_IDLE) ? cfg_fixed_dest : fixed_dest_reg;
    assign rr_sel      = (state_reg == S_IDLE) ? cfg_fixed_dest : rr_reg;
    assign rr_adv      = (rr_sel == LAST_DEST) ? '0 : rr_sel + DEST_W'(1);
    assign lfsr_step   = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

    always_comb begin
        dest_new = fixed_sel;
        case (pattern_sel)
            2'd1:    dest_new = fold_dest(lfsr_step[DEST_W-1:0]);
            2'd2:    dest_new = rr_sel;
            2'd3:    dest_new = fold_dest(SRC_COMP[DEST_W-1:0]);
            default: dest_new = fixed_sel;
        endcase
    end

    always_comb begin
        acc_sum  = {1'b0, acc_reg} + {2'b00, rate_reg};
        acc_next = '0;
        if (active) begin
            if (hs)                  acc_next = 8'(acc_sum - 9'd100);
            else if (acc_sum > 9'd199) acc_next = 8'd199;
            else                     acc_next = acc_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (cfg_start) state_next = (cfg_num_pkts != 16'd0) ? S_HDR : S_FINISH;
            S_HDR:     if (hs) state_next = S_PAYLOAD;
            S_PAYLOAD: if (last_hs) state_next = finish_cond ? S_FINISH : S_HDR;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = active;
        done          = (state_reg == S_FINISH);
        m_axis_tvalid = valid_int;
        m_axis_tlast  = is_last;
        m_axis_tdest  = active ? dest_reg : '0;
        beat_data     = '0;
        if (state_reg == S_HDR)
            beat_data = {seq_reg, SRC_ID, 8'(dest_reg), ts_value};
        else if (state_reg == S_PAYLOAD)
            beat_data = {seq_reg, 16'(beat_reg), 16'h0, ~16'(beat_reg)};
    end

    assign pkts_sent          = pkts_sent_reg;
    assign m_axis_tdata[63:0] = beat_data;

    generate
        if (DWIDTH > 64) begin : g_pad
            assign m_axis_tdata[DWIDTH-1:64] = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg        <= '0;
            ts_cnt_reg     <= '0;
            ts_hold_reg    <= '0;
            ts_held_reg    <= 1'b0;
            lfsr_reg       <= LFSR_SEED;
            num_pkts_reg   <= '0;
            lpp_reg        <= LPP_W'(2);
            rate_reg       <= 7'd1;
            pattern_reg    <= '0;
            fixed_dest_reg <= '0;
            rr_reg         <= '0;
            dest_reg       <= '0;
            seq_reg        <= '0;
            beat_reg       <= '0;
            pkts_sent_reg  <= '0;
            stop_reg       <= 1'b0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 32'd1;
            acc_reg    <= acc_next;
            if (start_acc) begin
                num_pkts_reg   <= cfg_num_pkts;
                lpp_reg        <= lpp_clamped;
                rate_reg       <= rate_clamped;
                pattern_reg    <= cfg_pattern;
                fixed_dest_reg <= cfg_fixed_dest;
                pkts_sent_reg  <= '0;
                seq_reg        <= '0;
                stop_reg       <= 1'b0;
            end
            if (hdr_entry) begin
                dest_reg    <= dest_new;
                rr_reg      <= rr_adv;
                lfsr_reg    <= lfsr_step;
                beat_reg    <= '0;
                ts_held_reg <= 1'b0;
            end
            // Freeze the timestamp the first cycle the header is offered.
            if (state_reg == S_HDR && valid_int && !ts_held_reg) begin
                ts_hold_reg <= ts_cnt_reg;
                ts_held_reg <= 1'b1;
            end
            if (hs) begin
                if (state_reg == S_HDR) beat_reg <= LPP_W'(1);
                else if (!is_last)      beat_reg <= beat_reg + LPP_W'(1);
            end
            if (last_hs) begin
                pkts_sent_reg <= pkts_sent_reg + 16'd1;
                seq_reg       <= seq_reg + 16'd1;
            end
            if (active && cfg_stop) stop_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_xbar_traffic_gen.sv
// Directed and randomized runs of the traffic generator checked against a
// packet-level reference model (beat contents, destinations, pacing).
module tb_axis_xbar_traffic_gen;
    localparam int          DWIDTH    = 64;
    localparam int          NUM_DESTS = 20;
    localparam int          DEST_W    = 5;
    localparam int          MTU_LOG2  = 5;
    localparam logic [7:0]  SRC_ID    = 8'h00;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [15:0]       cfg_num_pkts = '0;
    logic [MTU_LOG2:0] cfg_lpp = '0;
    logic [6:0]        cfg_inj_rate = '0;
    logic [1:0]        cfg_pattern = '0;
    logic [DEST_W-1:0] cfg_fixed_dest = '0;
    logic [DWIDTH-1:0] m_axis_tdata;
    logic [DEST_W-1:0] m_axis_tdest;
    logic              m_axis_tlast, m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              busy, done;
    logic [15:0]       pkts_sent;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc;
    logic [15:0] lfsr_m = SEED;

    axis_xbar_traffic_gen #(
        .DWIDTH(DWIDTH), .NUM_DESTS(NUM_DESTS), .DEST_W(DEST_W),
        .MTU_LOG2(MTU_LOG2), .SRC_ID(SRC_ID), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_num_pkts(cfg_num_pkts), .cfg_lpp(cfg_lpp),
        .cfg_inj_rate(cfg_inj_rate), .cfg_pattern(cfg_pattern),
        .cfg_fixed_dest(cfg_fixed_dest),
        .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp: cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_pkts(input int num, input int lpp, input int rate, input int pat,
                            input int fdest, input int ready_pct, input int stop_beat,
                            input int stall_pkt);
        int elpp, erate, exp_pkts, pkt, bidx, gbeat, busy_cyc, last_cyc, done_cyc, stall_cnt;
        int cur_dest;
        bit ts_seen, prev_stall, got_done;
        logic [31:0] ts_exp;
        logic [63:0] prev_data, exp_data;
        logic [DEST_W-1:0] prev_dest;
        logic prev_last;
        elpp  = (lpp < 2) ? 2 : ((lpp > (1 << MTU_LOG2)) ? (1 << MTU_LOG2) : lpp);
        erate = (rate == 0) ? 1 : ((rate > 100) ? 100 : rate);
        exp_pkts = num;
        if (stop_beat >= 0 && stop_beat / elpp + 1 < num) exp_pkts = stop_beat / elpp + 1;
        pkt = 0; bidx = 0; gbeat = 0; busy_cyc = 0; last_cyc = 0; done_cyc = 0;
        stall_cnt = 0; cur_dest = 0; ts_seen = 0; prev_stall = 0; got_done = 0;
        ts_exp = '0; prev_data = '0; prev_dest = '0; prev_last = 1'b0;

        @(negedge clk);
        cfg_num_pkts = 16'(num); cfg_lpp = 6'(lpp); cfg_inj_rate = 7'(rate);
        cfg_pattern = 2'(pat); cfg_fixed_dest = DEST_W'(fdest);
        cfg_start = 1'b1; m_axis_tready = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        // Scramble config: a run must only use the values latched at start.
        cfg_num_pkts = 16'($urandom); cfg_lpp = 6'($urandom); cfg_inj_rate = 7'($urandom);
        cfg_pattern = 2'($urandom); cfg_fixed_dest = DEST_W'($urandom);

        for (int c = 0; c < 20000; c++) begin
            if (c > 0) @(negedge clk);
            cfg_stop = 1'b0;
            if (done) begin got_done = 1; done_cyc = c; break; end
            if (busy) busy_cyc++;
            if (prev_stall) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_dest", 64'(m_axis_tdest), 64'(prev_dest));
                check("stall_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && bidx == 0 && !ts_seen) begin
                ts_seen = 1; ts_exp = cyc;
            end
            if (m_axis_tvalid && bidx == 0 && pkt == stall_pkt && stall_cnt < 10) begin
                m_axis_tready = 1'b0; stall_cnt++;
            end else begin
                m_axis_tready = ($urandom_range(99) < ready_pct);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata; prev_dest = m_axis_tdest; prev_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (bidx == 0) begin
                    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
                    case (pat)
                        0:       cur_dest = fdest;
                        1:       cur_dest = int'(lfsr_m % (1 << DEST_W)) % NUM_DESTS;
                        2:       cur_dest = (fdest + pkt) % NUM_DESTS;
                        default: cur_dest = int'((~SRC_ID) % (1 << DEST_W)) % NUM_DESTS;
                    endcase
                    exp_data = {pkt[15:0], SRC_ID, 8'(cur_dest), ts_exp};
                end else begin
                    exp_data = {pkt[15:0], 16'(bidx), 16'h0, ~16'(bidx)};
                end
                $display("[TB] beat pkt=%0d idx=%0d dest=%0d data=%h last=%0d",
                         pkt, bidx, m_axis_tdest, m_axis_tdata, m_axis_tlast);
                check($sformatf("data p%0d b%0d", pkt, bidx), m_axis_tdata, exp_data);
                check($sformatf("dest p%0d", pkt), 64'(m_axis_tdest), 64'(cur_dest));
                check($sformatf("tlast p%0d b%0d", pkt, bidx), 64'(m_axis_tlast),
                      64'(bidx == elpp - 1));
                if (gbeat == stop_beat) cfg_stop = 1'b1;
                gbeat++; last_cyc = c; bidx++;
                if (bidx == elpp) begin bidx = 0; pkt++; ts_seen = 0; end
            end
        end
        m_axis_tready = 1'b0;
        check("done_seen", 64'(got_done), 64'd1);
        check("beats", 64'(gbeat), 64'(exp_pkts * elpp));
        check("pkts_sent", 64'(pkts_sent), 64'(exp_pkts));
        check("busy_at_done", 64'(busy), 64'd0);
        if (gbeat > 0) check("done_latency", 64'(done_cyc - last_cyc), 64'd1);
        if (ready_pct >= 100 && stall_pkt < 0 && gbeat > 0)
            check("busy_cycles", 64'(busy_cyc), 64'((100 * gbeat + erate - 1) / erate + 1));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        $display("[TB] run num=%0d lpp=%0d rate=%0d pat=%0d beats=%0d busy_cycles=%0d",
                 num, lpp, rate, pat, gbeat, busy_cyc);
    endtask

    initial begin
        int nb;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkts", 64'(pkts_sent), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdest", 64'(m_axis_tdest), 64'd0);
        #2 rst_n = 1'b1;

        run_pkts(3, 4, 100, 0, 7, 100, -1, -1);     // back-to-back, fixed dest
        run_pkts(100, 2, 50, 0, 3, 100, -1, -1);    // strict alternation
        run_pkts(3, 4, 100, 0, 9, 100, -1, 1);      // header stalled 10 cycles
        run_pkts(4, 3, 100, 2, 18, 100, -1, -1);    // round-robin wrap
        run_pkts(10, 8, 100, 1, 0, 100, 18, -1);    // stop inside packet 3, random dest
        run_pkts(0, 4, 100, 0, 0, 100, -1, -1);     // empty run
        run_pkts(3, 2, 75, 3, 0, 70, -1, -1);       // bit-complement
        run_pkts(2, 0, 0, 0, 4, 100, -1, -1);       // lpp and rate clamped low
        run_pkts(2, 50, 120, 1, 0, 100, -1, -1);    // lpp and rate clamped high
        for (int i = 0; i < 6; i++)
            run_pkts(int'($urandom_range(6, 1)), int'($urandom_range(40, 0)),
                     int'($urandom_range(127, 20)), int'($urandom_range(3, 0)),
                     int'($urandom_range(NUM_DESTS - 1, 0)), int'($urandom_range(100, 50)),
                     -1, -1);

        // Reset in the middle of packet 1's payload.
        @(negedge clk);
        cfg_num_pkts = 16'd5; cfg_lpp = 6'd4; cfg_inj_rate = 7'd100;
        cfg_pattern = 2'd0; cfg_fixed_dest = 5'd5; cfg_start = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        nb = 0;
        for (int c = 0; c < 200 && nb < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) nb++;
        end
        @(negedge clk);
        check("mid_valid_pre", 64'(m_axis_tvalid), 64'd1);
        check("mid_pkts_pre", 64'(pkts_sent), 64'd1);
        #2 rst_n = 1'b0;
        lfsr_m = SEED;
        #1;
        check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pkts", 64'(pkts_sent), 64'd0);
        m_axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_done", 64'(done), 64'd0);
        end
        #2 rst_n = 1'b1;
        check("post_rst_done", 64'(done), 64'd0);
        run_pkts(2, 4, 100, 1, 0, 100, -1, -1);     // clean run after reset, LFSR reseeded

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_xbar_traffic_gen.md
Name: axis_xbar_traffic_gen

Overview:
- Synthesizable, parametrised AXI-Stream traffic generator for crossbar/router load-latency characterisation. It supersedes fixed-configuration simulation-only stimulus.
- Injects packets at a programmable rate, length and destination pattern.
- Header flits carry sequence number, source ID and a timestamp, so downstream checkers can measure latency.
- One instance per router input port. Usable in simulation and on hardware.

Parameters:
- DWIDTH, 64, datapath width; must be >= 64.
- NUM_DESTS, 20, number of router ports; destinations are 0..NUM_DESTS-1.
- DEST_W, 5, tdest width; must satisfy 2^DEST_W >= NUM_DESTS.
- MTU_LOG2, 5, log2 of maximum lines per packet.
- SRC_ID, 0, 8-bit source identifier placed in headers.
- LFSR_SEED, 16'hACE1, nonzero seed for the random-destination LFSR.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  single-cycle pulse that begins a run; ignored while busy.
- cfg_stop  in  1  pulse: finish the current packet, then end the run.
- cfg_num_pkts  in  16  packets per run.
- cfg_lpp  in  MTU_LOG2+1  lines per packet, header included.
- cfg_inj_rate  in  7  injection rate, percent of line rate (1..100).
- cfg_pattern  in  2  destination pattern: 0 fixed, 1 uniform random, 2 round-robin, 3 bit-complement of SRC_ID.
- cfg_fixed_dest  in  DEST_W  destination used by pattern 0, and start value for pattern 2.
- m_axis_tdata  out  DWIDTH  flit data.
- m_axis_tdest  out  DEST_W  packet destination.
- m_axis_tlast  out  1  last flit of packet.
- m_axis_tvalid  out  1  valid.
- m_axis_tready  in  1  ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pkts_sent  out  16  packets fully accepted in the current/last run.

Behaviour:
Reset (asynchronous, rst_n=0):
- All outputs 0.
- FSM in IDLE, credit accumulator 0, timestamp counter 0, LFSR = LFSR_SEED.

Configuration:
- All cfg_* values are latched on an accepted cfg_start. Later changes have no effect mid-run.
- cfg_lpp < 2 is treated as 2; cfg_lpp > 2^MTU_LOG2 is clamped to 2^MTU_LOG2.
- cfg_inj_rate = 0 is treated as 1; values > 100 are treated as 100.

FSM: IDLE -> HDR -> PAYLOAD -> (HDR | FINISH) -> IDLE.
- IDLE:
  - cfg_start with cfg_num_pkts > 0: go to HDR next cycle, busy = 1, pkts_sent = 0.
  - cfg_start with cfg_num_pkts = 0: go to FINISH.
- HDR: drive the header beat. On handshake, go to PAYLOAD.
- PAYLOAD: beat index runs 1..lpp-1; tlast = 1 on index lpp-1.
  - On the tlast handshake, pkts_sent increments.
  - If the new count equals num_pkts, or a stop is pending: go to FINISH.
  - Otherwise: go to HDR.
- FINISH: done = 1 for one cycle, busy = 0, return to IDLE.
- cfg_stop is remembered while busy. Packets are never truncated. cfg_stop in IDLE is ignored.

Rate control (credit accumulator acc, range 0..199):
- Each cycle in HDR/PAYLOAD: acc += rate, saturating at 199.
- On a beat handshake in the same cycle: acc += rate - 100.
- tvalid = (state is HDR or PAYLOAD) and acc >= 100.
- acc only falls on a handshake, so tvalid, once high, holds until accepted (AXI rule).
- tdata/tdest/tlast are stable while tvalid=1 and tready=0.
- Expected throughput: rate 100 gives one beat every cycle after the first; rate 50 gives strict alternation.
- acc is cleared on entering IDLE.

Timestamp and header:
- Free-running 32-bit counter, wraps.
- Header timestamp = counter value in the first cycle the header's tvalid is asserted; the value is frozen until the handshake.
- Header layout: [63:48] seq (16-bit, starts at 0 each run, wraps at 2^16), [47:40] SRC_ID, [39:32] dest zero-extended, [31:0] timestamp. Bits above 63 are 0.
- Payload layout: [63:48] seq, [47:32] beat index, [31:0] {16'h0, ~beat index[15:0]}.

Destination:
- Chosen at HDR entry; tdest is constant for the whole packet.
- Random pattern: LFSR (x^16+x^14+x^13+x^11+1) steps once per packet. Take the low DEST_W bits; if the value is >= NUM_DESTS, subtract NUM_DESTS.
- Round-robin: increments per packet and wraps NUM_DESTS-1 -> 0.
- Bit-complement: (~SRC_ID) mod NUM_DESTS, computed with the same subtract rule as random.

Test Plan:
- Reset asserted mid-run (during PAYLOAD with tvalid=1) -> tvalid, busy, pkts_sent all 0 immediately; no done pulse; new cfg_start after release runs cleanly from seq 0.
- rate=100, lpp=4, num_pkts=3, pattern 0, dest=7, tready=1 -> 12 consecutive beats, tlast on beats 4/8/12, tdest=7, seq 0,1,2, done one cycle after last beat, pkts_sent=3.
- rate=50, lpp=2, num_pkts=100, tready=1 -> tvalid toggles every cycle, 200 beats in 400±1 cycles.
- tready held 0 for 10 cycles during a header -> tdata (including timestamp) unchanged across the stall; timestamp equals the counter value at first tvalid.
- Pattern 2, NUM_DESTS=20, cfg_fixed_dest=18, num_pkts=4 -> tdest sequence 18, 19, 0, 1.
- cfg_stop asserted on beat 2 of packet 3 (lpp=8, num_pkts=10) -> packet 3 completes with tlast, pkts_sent=3, done pulse; cfg_num_pkts=0 start -> done with no beats.
